// File: rtl/pkt_send_scheduler_pkg.sv
// Shared definitions for the packet send scheduler: FSM state type and stats counter width.
package pkt_send_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RELEASE   = 2'd3
    } sched_state_t;

    localparam int MISSED_W = 16;

endpackage

// File: rtl/pkt_send_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr (wrapping) wins, one-hot.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         winner
);

    int unsigned idx;
    logic        found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_send_scheduler.sv
// Periodic send-slot scheduler with round-robin grant, transmitter handshake and watchdog.
// Define SCHED_STATS_EN to build the saturating missed-slot counter; otherwise missed_cnt reads 0.
module pkt_send_scheduler
    import pkt_send_scheduler_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int CNT_W   = 24,
    parameter int TMO_CYC = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [CNT_W-1:0]    period,
    input  logic [NREQ-1:0]     req,
    output logic [NREQ-1:0]     gnt,
    output logic                tx_start,
    input  logic                tx_done,
    output logic                busy,
    output logic                slot_tick,
    output logic                timeout,
    output logic [MISSED_W-1:0] missed_cnt
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int WD_W  = $clog2(TMO_CYC + 1);

    sched_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] win_q;
    logic [NREQ-1:0]  winner;
    logic [WD_W-1:0]  wd;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .winner (winner)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner[i]) win_idx = PTR_W'(i);
        end
    end

    // '>=' lets a lowered period take effect on the very next cycle
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt       <= '0;
            slot_tick <= 1'b0;
        end else if (cnt >= period) begin
            cnt       <= '0;
            slot_tick <= 1'b1;
        end else begin
            cnt       <= cnt + 1'b1;
            slot_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            tx_start <= 1'b0;
            timeout  <= 1'b0;
            busy     <= 1'b0;
            ptr      <= '0;
            win_q    <= '0;
            wd       <= '0;
        end else begin
            tx_start <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (slot_tick && |req) begin
                        state    <= ST_START;
                        gnt      <= winner;
                        win_q    <= win_idx;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_START: begin
                    wd    <= '0;
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    // done takes priority over a coincident watchdog expiry
                    if (tx_done) begin
                        state <= ST_RELEASE;
                        gnt   <= '0;
                    end else if (wd == WD_W'(TMO_CYC - 1)) begin
                        state   <= ST_RELEASE;
                        gnt     <= '0;
                        timeout <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    ptr   <= (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SCHED_STATS_EN
    logic [MISSED_W-1:0] missed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            missed_q <= '0;
        end else if (slot_tick && busy && missed_q != '1) begin
            missed_q <= missed_q + 1'b1;
        end
    end

    assign missed_cnt = missed_q;
`else
    assign missed_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_send_scheduler.sv
// Self-checking bench for pkt_send_scheduler: transaction-level reference model plus directed pins and random traffic.
module tb_pkt_send_scheduler;

    localparam int NREQ  = 4;
    localparam int CNT_W = 24;
    localparam int TMO   = 16;
`ifdef SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             enable  = 1'b0;
    logic             tx_done = 1'b0;
    logic [CNT_W-1:0] period  = 24'd9;
    logic [NREQ-1:0]  req     = '0;
    logic [NREQ-1:0]  gnt;
    logic             tx_start, busy, slot_tick, timeout;
    logic [15:0]      missed_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pkt_send_scheduler #(.NREQ(NREQ), .CNT_W(CNT_W), .TMO_CYC(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .period     (period),
        .req        (req),
        .gnt        (gnt),
        .tx_start   (tx_start),
        .tx_done    (tx_done),
        .busy       (busy),
        .slot_tick  (slot_tick),
        .timeout    (timeout),
        .missed_cnt (missed_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    // Transmitter stand-in: tx_done done_delay cycles after tx_start (0 = never), plus optional noise.
    int done_delay = 0;
    int done_cd    = 0;
    bit spurious   = 1'b0;

    always @(posedge clk) begin
        #2;
        tx_done = 1'b0;
        if (rst) begin
            done_cd = 0;
        end else begin
            if (done_cd > 0) begin
                done_cd--;
                if (done_cd == 0) tx_done = 1'b1;
            end
            if (tx_start === 1'b1 && done_delay > 0) done_cd = done_delay;
            if (spurious && $urandom_range(0, 15) == 0) tx_done = 1'b1;
        end
    end

    // Reference model: a transfer is a record (start cycle, end cycle, winner, cause); outputs follow from it.
    int cyc = 0;
    bit mv = 1'b0, act = 1'b0, ended = 1'b0, by_tmo = 1'b0, m_tick = 1'b0;
    int m_cnt = 0, s_cyc = 0, e_cyc = 0, win = 0, ptr = 0, missed = 0;

    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        bit was_act;
        cyc++;
        if (mv) begin
            eg = '0;
            if (act && cyc >= s_cyc && !(ended && cyc >= e_cyc)) eg[win] = 1'b1;
            chk("slot_tick",  32'(slot_tick),  32'(m_tick));
            chk("busy",       32'(busy),       32'(act));
            chk("tx_start",   32'(tx_start),   32'(act && cyc == s_cyc));
            chk("gnt",        32'(gnt),        32'(eg));
            chk("timeout",    32'(timeout),    32'(act && ended && by_tmo && cyc == e_cyc));
            chk("missed_cnt", 32'(missed_cnt), 32'(STATS ? missed : 0));
        end
        if (rst) begin
            mv = 1'b1; act = 1'b0; ended = 1'b0; m_tick = 1'b0;
            m_cnt = 0; ptr = 0; missed = 0;
        end else begin
            was_act = act;
            if (m_tick) begin
                if (!was_act) begin
                    if (req != '0) begin
                        win = pick(req, ptr); act = 1'b1; ended = 1'b0; s_cyc = cyc + 1;
                    end
                end else if (missed < 65535) begin
                    missed++;
                end
            end
            if (was_act) begin
                if (ended && cyc == e_cyc) begin
                    act = 1'b0;
                    ptr = (win + 1) % NREQ;
                end else if (!ended && cyc > s_cyc) begin
                    if (tx_done) begin
                        ended = 1'b1; by_tmo = 1'b0; e_cyc = cyc + 1;
                    end else if (cyc - s_cyc == TMO) begin
                        ended = 1'b1; by_tmo = 1'b1; e_cyc = cyc + 1;
                    end
                end
            end
            if (!enable) begin
                m_tick = 1'b0; m_cnt = 0;
            end else if (m_cnt >= int'(period)) begin
                m_tick = 1'b1; m_cnt = 0;
            end else begin
                m_tick = 1'b0; m_cnt++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        step(1);
        rst = 1'b1; enable = 1'b0;
        step(2);
        rst = 1'b0; enable = 1'b1;
    endtask

    task automatic wait_start(input string name, output int n, output bit prev_tick);
        bit got = 1'b0;
        bit last = 1'b0;
        n = 0;
        prev_tick = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (tx_start === 1'b1) begin
                got = 1'b1; prev_tick = last;
                break;
            end
            last = (slot_tick === 1'b1);
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL %s: no tx_start within 300 cycles", name);
        end
    endtask

    task automatic wait_tmo(input string name, output int n);
        bit got = 1'b0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (timeout === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL %s: no timeout within 300 cycles", name);
        end
    endtask

    initial begin
        int n, tcount;
        bit pt;
        logic [NREQ-1:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        step(3);
        rst = 1'b0;

        // slot every 10 cycles, start one cycle after tick, grant drops after done at +3
        period = 24'd9; req = 4'b0001; done_delay = 3;
        do_reset();
        wait_start("t1_first", n, pt);
        chk("t1_tick_to_start", 32'(pt), 32'd1);
        chk("t1_gnt", 32'(gnt), 32'd1);
        wait_start("t1_second", n, pt);
        chk("t1_slot_period", 32'(n), 32'd10);
        repeat (3) @(negedge clk);
        chk("t1_gnt_held", 32'(gnt), 32'd1);
        @(negedge clk);
        chk("t1_gnt_drop", 32'(gnt), 32'd0);

        // round-robin rotation with all requesters active
        req = 4'b1111; done_delay = 1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wait_start("t2_start", n, pt);
            chk("t2_rr_gnt", 32'(gnt), 32'(seq[i]));
        end

        // two slots lost while a long transfer is outstanding
        period = 24'd4; req = 4'b0001; done_delay = 12;
        do_reset();
        wait_start("t3_start", n, pt);
        repeat (14) @(negedge clk);
        chk("t3_missed", 32'(missed_cnt), STATS ? 32'd2 : 32'd0);
        chk("t3_idle", 32'(busy), 32'd0);

        // watchdog expiry, then the next requester is served
        req = 4'b0011; done_delay = 0;
        do_reset();
        wait_start("t4_start", n, pt);
        chk("t4_gnt0", 32'(gnt), 32'd1);
        wait_tmo("t4_tmo", n);
        chk("t4_tmo_latency", 32'(n), 32'd17);
        chk("t4_gnt_drop", 32'(gnt), 32'd0);
        wait_start("t4_next", n, pt);
        chk("t4_gnt1", 32'(gnt), 32'd2);

        // done coincident with expiry: no timeout pulse
        period = 24'd30; req = 4'b0001; done_delay = 16;
        do_reset();
        wait_start("t5_start", n, pt);
        tcount = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (timeout === 1'b1) tcount++;
            if (k == 16) chk("t5_gnt_held", 32'(gnt), 32'd1);
            if (k == 17) begin
                chk("t5_release_gnt", 32'(gnt), 32'd0);
                chk("t5_release_busy", 32'(busy), 32'd1);
            end
        end
        chk("t5_no_timeout", 32'(tcount), 32'd0);

        // reset in WAIT_DONE abandons the transfer and restores req[0] priority
        period = 24'd4; req = 4'b1111; done_delay = 1;
        do_reset();
        wait_start("t6_first", n, pt);
        done_delay = 0;
        wait_start("t6_second", n, pt);
        chk("t6_gnt_before", 32'(gnt), 32'd2);
        repeat (8) @(negedge clk);
        chk("t6_missed_before", 32'(missed_cnt), STATS ? 32'd1 : 32'd0);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("t6_gnt", 32'(gnt), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_missed", 32'(missed_cnt), 32'd0);
        chk("t6_timeout", 32'(timeout), 32'd0);
        wait_start("t6_after", n, pt);
        chk("t6_gnt_after", 32'(gnt), 32'd1);

        // random traffic against the model
        do_reset();
        spurious = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0)   req = NREQ'($urandom);
            if ($urandom_range(0, 49) == 0)  enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 199) == 0) period = CNT_W'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0)  done_delay = int'($urandom_range(0, 20));
            rst = ($urandom_range(0, 799) == 0);
        end
        rst = 1'b0;
        spurious = 1'b0;
        step(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
